reg_bank_writer: RTL and testbench

- Write side of the register bank. It holds general registers r0..r27, special registers r32/r33, the Working_Register (address 34) and Output_Port_0/1 (addresses 30/31).
- It accepts one write per cycle from the execute/write-back stage.
- It drives every stored register out continuously to the operand-fetch mux (Sel_A/Sel_B side).
- A sequenced bulk-clear FSM zeroes the bank on request. A sticky error flag records illegal writes.

---
 rtl/reg_bank_pkg.sv | 30 +++
 rtl/reg_bank_writer_if.sv | 32 +++
 rtl/reg_wr_decode.sv | 33 +++
 rtl/reg_bank_writer.sv | 167 ++++++++++++++++
 tb/tb_reg_bank_writer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_pkg
// Description : Shared constants, address map and FSM encoding for the
//               register bank write side and its operand-fetch read mux.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_bank_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;
    // Slots indexed directly by address 0..34. Slots 28/29 are the read-only
    // input ports and carry no storage.
    localparam int SLOT_N = 35;

    localparam logic [ADDR_W-1:0] ADDR_PI0  = 6'd28;
    localparam logic [ADDR_W-1:0] ADDR_PI1  = 6'd29;
    localparam logic [ADDR_W-1:0] ADDR_PO0  = 6'd30;
    localparam logic [ADDR_W-1:0] ADDR_PO1  = 6'd31;
    localparam logic [ADDR_W-1:0] ADDR_R32  = 6'd32;
    localparam logic [ADDR_W-1:0] ADDR_R33  = 6'd33;
    localparam logic [ADDR_W-1:0] ADDR_WREG = 6'd34;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_bank_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_writer_if
// Description : Write/clear bus between the execute/write-back stage (master)
//               and the register bank write side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_bank_writer_if #(
    parameter int DATA_W = reg_bank_pkg::DATA_W
);
    import reg_bank_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] Sel_C;
    logic [DATA_W-1:0] Data_C;
    logic              clear_req;
    logic              wr_err_clr;
    logic              busy;
    logic              wr_err;

    modport master (
        output wr_en, Sel_C, Data_C, clear_req, wr_err_clr,
        input  busy, wr_err
    );

    modport slave (
        input  wr_en, Sel_C, Data_C, clear_req, wr_err_clr,
        output busy, wr_err
    );

endinterface
`default_nettype wire

// File: rtl/reg_wr_decode.sv
`default_nettype none
// ============================================================================
// Module      : reg_wr_decode
// Description : Address to one-hot slot write-enable decoder with an illegal
//               flag for read-only and unmapped addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_wr_decode
    import reg_bank_pkg::*;
#(
    parameter int NUM_GPR = 28
) (
    input  wire logic [ADDR_W-1:0] addr,
    output logic      [SLOT_N-1:0] we_hot,
    output logic                   illegal
);

    localparam logic [ADDR_W-1:0] c_GPR_END = ADDR_W'(NUM_GPR);

    logic w_mapped;

    // Writable = general registers or the 30..34 block; anything else is dropped.
    always_comb begin
        w_mapped = (addr < c_GPR_END) || ((addr >= ADDR_PO0) && (addr <= ADDR_WREG));
        we_hot   = '0;
        if (w_mapped) begin
            we_hot = SLOT_N'(1) << addr;
        end
        illegal  = ~w_mapped;
    end

endmodule
`default_nettype wire

// File: rtl/reg_bank_writer.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_writer
// Description : Register bank write side: single write per cycle, continuous
//               register outputs, sequenced bulk clear and sticky write error.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_writer #(
    parameter int DATA_W   = reg_bank_pkg::DATA_W,
    parameter int NUM_GPR  = 28,
    parameter int CLR_LAST = 34
) (
    input  wire logic              clk,
    input  wire logic              reset,
    reg_bank_writer_if.slave       bus,
    output logic [DATA_W-1:0]      r0,  r1,  r2,  r3,  r4,  r5,  r6,
    output logic [DATA_W-1:0]      r7,  r8,  r9,  r10, r11, r12, r13,
    output logic [DATA_W-1:0]      r14, r15, r16, r17, r18, r19, r20,
    output logic [DATA_W-1:0]      r21, r22, r23, r24, r25, r26, r27,
    output logic [DATA_W-1:0]      r32,
    output logic [DATA_W-1:0]      r33,
    output logic [DATA_W-1:0]      Working_Register,
    output logic [DATA_W-1:0]      Output_Port_0,
    output logic [DATA_W-1:0]      Output_Port_1
);
    import reg_bank_pkg::*;

    localparam logic [ADDR_W-1:0] c_CLR_LAST = ADDR_W'(CLR_LAST);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic              r_wr_err;
    logic [ADDR_W-1:0] w_dec_addr;
    logic [SLOT_N-1:0] w_dec_hot;
    logic              w_dec_ill;
    logic [SLOT_N-1:0] w_slot_we;
    logic [DATA_W-1:0] w_slot_d;
    logic              w_err_set;
    logic [DATA_W-1:0] w_slot [0:SLOT_N-1];

    // The single decoder serves the write port in IDLE and the sequencer in CLEAR.
    assign w_dec_addr = (r_state == CLEAR) ? r_idx : bus.Sel_C;

    reg_wr_decode #(
        .NUM_GPR (NUM_GPR)
    ) u_decode (
        .addr    (w_dec_addr),
        .we_hot  (w_dec_hot),
        .illegal (w_dec_ill)
    );

    // Next-state, clear index and slot write selection.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_slot_we   = '0;
        w_slot_d    = bus.Data_C;
        w_err_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.wr_en) begin
                    w_slot_we = w_dec_hot;
                    w_err_set = w_dec_ill;
                end
                // A write in the same cycle still lands; the sequence zeroes it later.
                if (bus.clear_req) begin
                    w_state_nxt = CLEAR;
                    w_idx_nxt   = '0;
                end
            end
            CLEAR: begin
                // Read-only indices decode to no enable, so they are skipped silently.
                w_slot_we = w_dec_hot;
                w_slot_d  = '0;
                w_err_set = bus.wr_en;
                if (r_idx == c_CLR_LAST) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt   = r_idx + 6'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // State, index and sticky error register; a new error beats a clear request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_wr_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_err_set) begin
                r_wr_err <= 1'b1;
            end else if (bus.wr_err_clr) begin
                r_wr_err <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < SLOT_N; k++) begin : g_slot
        if ((k < NUM_GPR) || (k >= int'(ADDR_PO0))) begin : g_rw
            logic [DATA_W-1:0] r_q;
            // Storage for one writable address.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_q <= '0;
                end else if (w_slot_we[k]) begin
                    r_q <= w_slot_d;
                end
            end
            assign w_slot[k] = r_q;
        end else begin : g_ro
            logic w_unused_we;
            assign w_unused_we = w_slot_we[k];
            assign w_slot[k]   = '0;
        end
    end

    assign bus.busy   = (r_state == CLEAR);
    assign bus.wr_err = r_wr_err;

    assign r0  = w_slot[0];
    assign r1  = w_slot[1];
    assign r2  = w_slot[2];
    assign r3  = w_slot[3];
    assign r4  = w_slot[4];
    assign r5  = w_slot[5];
    assign r6  = w_slot[6];
    assign r7  = w_slot[7];
    assign r8  = w_slot[8];
    assign r9  = w_slot[9];
    assign r10 = w_slot[10];
    assign r11 = w_slot[11];
    assign r12 = w_slot[12];
    assign r13 = w_slot[13];
    assign r14 = w_slot[14];
    assign r15 = w_slot[15];
    assign r16 = w_slot[16];
    assign r17 = w_slot[17];
    assign r18 = w_slot[18];
    assign r19 = w_slot[19];
    assign r20 = w_slot[20];
    assign r21 = w_slot[21];
    assign r22 = w_slot[22];
    assign r23 = w_slot[23];
    assign r24 = w_slot[24];
    assign r25 = w_slot[25];
    assign r26 = w_slot[26];
    assign r27 = w_slot[27];

    assign Output_Port_0    = w_slot[ADDR_PO0];
    assign Output_Port_1    = w_slot[ADDR_PO1];
    assign r32              = w_slot[ADDR_R32];
    assign r33              = w_slot[ADDR_R33];
    assign Working_Register = w_slot[ADDR_WREG];

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_writer
// Description : Self-checking bench for reg_bank_writer: vector table,
//               hand-written clear sequences and randomized traffic against
//               an address-map reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_writer;
    import reg_bank_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic [15:0] gpr [0:27];
    logic [15:0] r32, r33, wreg, po0, po1;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    logic [15:0] m_reg [0:34];
    bit          m_err;
    int          m_left;

    reg_bank_writer_if #(.DATA_W(16)) bus ();

    reg_bank_writer #(.DATA_W(16), .NUM_GPR(28), .CLR_LAST(34)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .r0(gpr[0]),   .r1(gpr[1]),   .r2(gpr[2]),   .r3(gpr[3]),
        .r4(gpr[4]),   .r5(gpr[5]),   .r6(gpr[6]),   .r7(gpr[7]),
        .r8(gpr[8]),   .r9(gpr[9]),   .r10(gpr[10]), .r11(gpr[11]),
        .r12(gpr[12]), .r13(gpr[13]), .r14(gpr[14]), .r15(gpr[15]),
        .r16(gpr[16]), .r17(gpr[17]), .r18(gpr[18]), .r19(gpr[19]),
        .r20(gpr[20]), .r21(gpr[21]), .r22(gpr[22]), .r23(gpr[23]),
        .r24(gpr[24]), .r25(gpr[25]), .r26(gpr[26]), .r27(gpr[27]),
        .r32(r32), .r33(r33), .Working_Register(wreg),
        .Output_Port_0(po0), .Output_Port_1(po1)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic bit writable(int a);
        return (a < 28) || ((a >= 30) && (a <= 34));
    endfunction

    function automatic logic [15:0] get_out(int a);
        if (a < 28) return gpr[a];
        case (a)
            30:      return po0;
            31:      return po1;
            32:      return r32;
            33:      return r33;
            34:      return wreg;
            default: return 16'h0;
        endcase
    endfunction

    task automatic chk(string name, int idx, logic [15:0] act, logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] actual=%h required=%h at %0t", name, idx, act, exp, $time);
        end
    endtask

    // Behaviour taken from the address map and clear rules, one edge at a time.
    task automatic model_step();
        bit e;
        int a;
        e = 1'b0;
        if (reset) begin
            for (int i = 0; i < 35; i++) m_reg[i] = 16'h0;
            m_err  = 1'b0;
            m_left = 0;
        end else if (m_left > 0) begin
            a = 35 - m_left;
            if (writable(a)) m_reg[a] = 16'h0;
            if (bus.wr_en) m_err = 1'b1;
            else if (bus.wr_err_clr) m_err = 1'b0;
            m_left--;
        end else begin
            if (bus.wr_en) begin
                if (writable(int'(bus.Sel_C))) m_reg[int'(bus.Sel_C)] = bus.Data_C;
                else e = 1'b1;
            end
            if (e) m_err = 1'b1;
            else if (bus.wr_err_clr) m_err = 1'b0;
            if (bus.clear_req) m_left = 35;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        for (int a = 0; a < 35; a++)
            if (writable(a)) chk("model_reg", a, get_out(a), m_reg[a]);
        chk("model_busy", 0, 16'(bus.busy), 16'(m_left > 0));
        chk("model_err", 0, 16'(bus.wr_err), 16'(m_err));
    endtask

    task automatic drive(bit rst, bit we, logic [5:0] sel, logic [15:0] dat, bit creq, bit eclr);
        reset          = rst;
        bus.wr_en      = we;
        bus.Sel_C      = sel;
        bus.Data_C     = dat;
        bus.clear_req  = creq;
        bus.wr_err_clr = eclr;
    endtask

    task automatic wr(logic [5:0] sel, logic [15:0] dat);
        drive(0, 1, sel, dat, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        bit          rst;
        bit          we;
        logic [5:0]  sel;
        logic [15:0] dat;
        bit          creq;
        bit          eclr;
        int          ca;
        logic [15:0] cv;
        bit          ce;
    } vec_t;

    vec_t tv [12];

    initial begin
        int n;
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 35; i++) m_reg[i] = 16'hxxxx;
        m_err  = 1'b0;
        m_left = 0;

        //         rst we sel   data      creq eclr chk  value     err
        tv[0]  = '{1, 0, 6'd0,  16'h0000, 0, 0,  5,  16'h0000, 0};
        tv[1]  = '{1, 0, 6'd0,  16'h0000, 0, 0,  34, 16'h0000, 0};
        tv[2]  = '{0, 1, 6'd5,  16'hA5A5, 0, 0,  5,  16'hA5A5, 0};
        tv[3]  = '{0, 1, 6'd34, 16'h1234, 0, 0,  34, 16'h1234, 0};
        tv[4]  = '{0, 0, 6'd0,  16'h0000, 0, 0,  0,  16'h0000, 0};
        tv[5]  = '{0, 1, 6'd30, 16'h00FF, 0, 0,  30, 16'h00FF, 0};
        tv[6]  = '{0, 1, 6'd31, 16'hFF00, 0, 0,  31, 16'hFF00, 0};
        tv[7]  = '{0, 1, 6'd28, 16'hDEAD, 0, 0,  5,  16'hA5A5, 1};
        tv[8]  = '{0, 1, 6'd40, 16'hBEEF, 0, 0,  34, 16'h1234, 1};
        tv[9]  = '{0, 0, 6'd0,  16'h0000, 0, 1,  30, 16'h00FF, 0};
        tv[10] = '{0, 1, 6'd29, 16'hCAFE, 0, 1,  31, 16'hFF00, 1};
        tv[11] = '{0, 0, 6'd0,  16'h0000, 0, 1,  0,  16'h0000, 0};

        for (int i = 0; i < 12; i++) begin
            drive(tv[i].rst, tv[i].we, tv[i].sel, tv[i].dat, tv[i].creq, tv[i].eclr);
            cycle();
            chk("vec_reg", i, get_out(tv[i].ca), tv[i].cv);
            chk("vec_err", i, 16'(bus.wr_err), 16'(tv[i].ce));
        end
        drive(0, 0, 0, 0, 0, 0);

        // bulk clear with preload, a dropped write and a second request
        wr(6'd0, 16'h0001);
        wr(6'd27, 16'h0002);
        wr(6'd33, 16'h0003);
        wr(6'd34, 16'h0004);
        drive(0, 0, 0, 0, 1, 0);
        cycle();
        chk("clr_busy_start", 0, 16'(bus.busy), 16'h1);
        n = 0;
        while (bus.busy && n < 100) begin
            drive(0, n == 3, 6'd3, 16'hFFFF, n == 15, 0);
            cycle();
            n++;
            if (n == 4) chk("clr_drop_err", 0, 16'(bus.wr_err), 16'h1);
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("clr_busy_len", 0, 16'(n), 16'd35);
        for (int a = 0; a < 35; a++)
            if (writable(a)) chk("clr_zero", a, get_out(a), 16'h0);
        drive(0, 0, 0, 0, 0, 1);
        cycle();
        drive(0, 0, 0, 0, 0, 0);

        // reset in the middle of a clear
        wr(6'd20, 16'h5555);
        drive(0, 0, 0, 0, 1, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle();
        drive(1, 0, 0, 0, 0, 0);
        cycle();
        chk("rst_mid_busy", 0, 16'(bus.busy), 16'h0);
        chk("rst_mid_r20", 20, gpr[20], 16'h0);
        drive(0, 0, 0, 0, 0, 0);
        wr(6'd7, 16'h7777);
        chk("rst_mid_r7", 7, gpr[7], 16'h7777);

        // write and clear request in the same cycle
        drive(0, 1, 6'd0, 16'hBEEF, 1, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("coll_r0", 0, gpr[0], 16'hBEEF);
        chk("coll_busy", 0, 16'(bus.busy), 16'h1);
        n = 0;
        while (bus.busy && n < 100) begin
            cycle();
            n++;
            if (n == 1) chk("coll_r0_zero", 0, gpr[0], 16'h0);
        end
        chk("coll_busy_len", 0, 16'(n), 16'd35);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] s;
            s = ($urandom_range(1) == 0) ? 6'($urandom_range(34)) : 6'($urandom_range(63));
            drive($urandom_range(199) == 0, $urandom_range(1) == 1, s, 16'($urandom),
                  $urandom_range(39) == 0, $urandom_range(7) == 0);
            cycle();
        end
        drive(0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
